// File: rtl/switch_input_port_pkg.sv
// Shared IO map for the CPU/memory top and the memory-mapped peripherals.
// Also holds the packed event-flag record used by the switch input port.
package switch_input_port_pkg;

  localparam logic [15:0] SWITCHES_LOC = 16'hCFFD;
  localparam logic [15:0] LEDS_LOC     = 16'hCFFE;
  localparam logic [15:0] EVENT_LOC    = 16'hCFFF;
  localparam logic [15:0] IO_MEM       = 16'hCFFD;

  // Read back as {rise, fall}, so rise occupies the upper byte.
  typedef struct packed {
    logic [7:0] rise;
    logic [7:0] fall;
  } evt_flags_t;

endpackage

// File: rtl/switch_input_port_if.sv
// CPU port-A read bus as seen by a memory-mapped IO peripheral.
// rd_data/hit are registered by the peripheral: valid the cycle after rd_en.
interface switch_input_port_if;
  logic [15:0] address;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        hit;

  modport master (output address, rd_en, input rd_data, hit);
  modport slave  (input address, rd_en, output rd_data, hit);
endinterface

// File: rtl/switch_input_port_sync_debounce.sv
// Two-flop synchroniser plus whole-vector debounce with a single counter.
// Latency raw edge -> db change: 2 sync + 1 candidate + DEBOUNCE_CYCLES cycles.
// commit is combinational: high in the cycle whose closing edge updates db.
module sync_debounce #(
  parameter int          WIDTH           = 8,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] db,
  output logic [WIDTH-1:0] db_next,
  output logic             commit
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] cand_q,  cand_d;
  logic [WIDTH-1:0] db_q,    db_d;
  logic [15:0]      count_q, count_d;

  // Next-state: synchronise, track candidate, count a stable window, commit.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    db_d    = db_q;
    count_d = count_q;
    commit  = 1'b0;
    if (sync2_q != cand_q) begin
      // Any change on any bit restarts the window for the whole vector.
      cand_d  = sync2_q;
      count_d = 16'd0;
    end else if (cand_q != db_q) begin
      if (count_q == DEBOUNCE_CYCLES - 16'd1) begin
        db_d    = cand_q;
        count_d = 16'd0;
        commit  = 1'b1;
      end else begin
        count_d = count_q + 16'd1;
      end
    end else begin
      count_d = 16'd0;
    end
  end

  // State registers; reset discards any candidate in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      db_q    <= '0;
      count_q <= 16'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      db_q    <= db_d;
      count_q <= count_d;
    end
  end

  assign db      = db_q;
  assign db_next = cand_q;

endmodule

// File: rtl/switch_input_port.sv
// Debounced board-switch peripheral with sticky clear-on-read edge events and irq.
// Read data registered, one-cycle latency (same timing as EXRAM q_a).
// No backpressure: every rd_en is answered on the following cycle.
module switch_input_port
  import switch_input_port_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] SWITCHES_LOC    = switch_input_port_pkg::SWITCHES_LOC,
  parameter logic [15:0] EVENT_LOC       = switch_input_port_pkg::EVENT_LOC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 switches_raw,
  switch_input_port_if.slave         bus,
  output logic [7:0]                 switches_db,
  output logic                       irq
);

  logic [7:0] db;
  logic [7:0] db_next;
  logic       commit;

  sync_debounce #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk     (clk),
    .reset   (reset),
    .din     (switches_raw),
    .db      (db),
    .db_next (db_next),
    .commit  (commit)
  );

  evt_flags_t  flags_q, flags_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        hit_q, hit_d;
  logic        sw_rd;
  logic        ev_rd;

  // Flag update and read mux; an event read clears old flags but keeps edges
  // committed on the same edge, and always returns the pre-update state.
  always_comb begin
    sw_rd     = bus.rd_en && (bus.address == SWITCHES_LOC);
    ev_rd     = bus.rd_en && (bus.address == EVENT_LOC);
    flags_d   = ev_rd ? '0 : flags_q;
    if (commit) begin
      flags_d.rise = flags_d.rise | (db_next & ~db);
      flags_d.fall = flags_d.fall | (~db_next & db);
    end
    rd_data_d = 16'h0000;
    hit_d     = 1'b0;
    if (sw_rd) begin
      rd_data_d = {8'h00, db};
      hit_d     = 1'b1;
    end else if (ev_rd) begin
      rd_data_d = flags_q;
      hit_d     = 1'b1;
    end
  end

  // Registered flags and read response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= '0;
      rd_data_q <= 16'h0000;
      hit_q     <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      rd_data_q <= rd_data_d;
      hit_q     <= hit_d;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.hit     = hit_q;
  assign switches_db = db;
  assign irq         = |flags_q;

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port with DEBOUNCE_CYCLES=4 (commit 7 edges after raw change).
module tb_switch_input_port;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] switches_raw = 8'h00;
  logic [7:0] switches_db;
  logic       irq;

  switch_input_port_if bus ();

  switch_input_port #(.DEBOUNCE_CYCLES(16'd4)) dut (
    .clk          (clk),
    .reset        (reset),
    .switches_raw (switches_raw),
    .bus          (bus),
    .switches_db  (switches_db),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle read strobe; returns just after the edge that registers the response.
  task automatic rd(input logic [15:0] addr);
    bus.address = addr;
    bus.rd_en   = 1'b1;
    tick();
    bus.rd_en   = 1'b0;
    bus.address = 16'h0000;
  endtask

  // Drive a new raw value; check no change after 6 edges and the commit on the 7th.
  task automatic settle(input string tag, input logic [7:0] oldv, input logic [7:0] newv);
    switches_raw = newv;
    repeat (6) tick();
    chk({tag, "_db_pre"}, {8'h00, switches_db}, {8'h00, oldv});
    tick();
    chk({tag, "_db_post"}, {8'h00, switches_db}, {8'h00, newv});
  endtask

  initial begin
    bus.address = 16'h0000;
    bus.rd_en   = 1'b0;

    // Asynchronous reset asserted between edges.
    #23;
    reset = 1'b1;
    #1;
    chk("rst_rd_data", bus.rd_data, 16'h0000);
    chk("rst_hit", {15'd0, bus.hit}, 16'h0000);
    chk("rst_db", {8'h00, switches_db}, 16'h0000);
    chk("rst_irq", {15'd0, irq}, 16'h0000);
    switches_raw = 8'hA5;
    tick();
    tick();
    reset = 1'b0;

    // No irq on release; first commit compares against 0.
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rel_no_irq", {15'd0, irq}, 16'h0000);
    end
    tick();
    chk("rel_db_a5", {8'h00, switches_db}, 16'h00A5);
    chk("rel_irq", {15'd0, irq}, 16'h0001);
    rd(16'hCFFF);
    chk("rel_evt", bus.rd_data, 16'hA500);
    chk("rel_evt_hit", {15'd0, bus.hit}, 16'h0001);

    // Back to 0, then 0x81.
    settle("to00", 8'hA5, 8'h00);
    rd(16'hCFFF);
    chk("to00_evt", bus.rd_data, 16'h00A5);
    settle("to81", 8'h00, 8'h81);
    chk("to81_irq_hi", {15'd0, irq}, 16'h0001);
    rd(16'hCFFF);
    chk("to81_evt", bus.rd_data, 16'h8100);
    chk("to81_irq_lo", {15'd0, irq}, 16'h0000);
    tick();
    chk("idle_hit", {15'd0, bus.hit}, 16'h0000);
    chk("idle_rd_data", bus.rd_data, 16'h0000);
    settle("back00", 8'h81, 8'h00);
    rd(16'hCFFF);
    chk("back00_evt", bus.rd_data, 16'h0081);

    // Bounce on bit 0 every 2 cycles, then hold 1.
    for (int i = 0; i < 10; i++) begin
      switches_raw = (i % 2 == 0) ? 8'h01 : 8'h00;
      tick();
      chk("bounce_db", {8'h00, switches_db}, 16'h0000);
      tick();
      chk("bounce_db", {8'h00, switches_db}, 16'h0000);
    end
    chk("bounce_irq", {15'd0, irq}, 16'h0000);
    settle("hold01", 8'h00, 8'h01);
    chk("hold01_irq", {15'd0, irq}, 16'h0001);

    // Event read landing on the commit edge of 01 -> 00.
    switches_raw = 8'h00;
    repeat (6) tick();
    chk("cc_db_pre", {8'h00, switches_db}, 16'h0001);
    rd(16'hCFFF);
    chk("cc_evt", bus.rd_data, 16'h0100);
    chk("cc_db_post", {8'h00, switches_db}, 16'h0000);
    chk("cc_irq", {15'd0, irq}, 16'h0001);
    rd(16'hCFFF);
    chk("cc_evt2", bus.rd_data, 16'h0001);
    chk("cc_irq_lo", {15'd0, irq}, 16'h0000);

    // Switch read during its own commit returns the pre-commit value.
    switches_raw = 8'h3C;
    repeat (6) tick();
    rd(16'hCFFD);
    chk("swc_rd_data", bus.rd_data, 16'h0000);
    chk("swc_hit", {15'd0, bus.hit}, 16'h0001);
    chk("swc_db", {8'h00, switches_db}, 16'h003C);
    rd(16'hCFFD);
    chk("sw_rd_data", bus.rd_data, 16'h003C);
    chk("sw_hit", {15'd0, bus.hit}, 16'h0001);
    rd(16'hCFFE);
    chk("leds_rd_data", bus.rd_data, 16'h0000);
    chk("leds_hit", {15'd0, bus.hit}, 16'h0000);
    rd(16'hCFFF);
    chk("sw_evt", bus.rd_data, 16'h3C00);

    // Fall path FF -> 0F.
    settle("toFF", 8'h3C, 8'hFF);
    rd(16'hCFFF);
    chk("toFF_evt", bus.rd_data, 16'hC300);
    settle("to0F", 8'hFF, 8'h0F);
    rd(16'hCFFF);
    chk("to0F_evt", bus.rd_data, 16'h00F0);
    rd(16'hCFFF);
    chk("to0F_evt2", bus.rd_data, 16'h0000);
    chk("to0F_hit2", {15'd0, bus.hit}, 16'h0001);
    chk("end_irq", {15'd0, irq}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
